// File: rtl/packet_uart_tx.sv
// rtl/packet_uart_tx.sv - frame-atomic 8N1 UART transmitter for the screen packet, MSB byte first.
// Define PACKET_UART_SYNC_EN to prefix every frame with the 0xA5 sync byte.
module packet_uart_tx #(
  parameter int CLK_DIV   = 868,
  parameter int PKT_BYTES = 22
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   print_e,
  input  logic [8*PKT_BYTES-1:0] packet,
  output logic                   TxD,
  output logic                   busy,
  output logic                   overrun,
  output logic [15:0]            frame_cnt
);

`ifdef PACKET_UART_SYNC_EN
  localparam int NBYTES = PKT_BYTES + 1;
`else
  localparam int NBYTES = PKT_BYTES;
`endif
  localparam int BW = 8 * NBYTES;
  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);
  localparam logic [15:0]   BAUD_END = 16'(CLK_DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  state_e          state_q, state_d;
  logic            pe_q;
  logic [15:0]     baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [BW-1:0]   buf_q, buf_d;
  logic            txd_q, txd_d;
  logic            busy_q, busy_d;
  logic            ovr_q, ovr_d;
  logic [15:0]     fcnt_q, fcnt_d;

  logic            rise, bit_end;
  logic [7:0]      cur_byte;
  logic [2:0]      next_bit;
  logic [BW-1:0]   capture;

  assign rise     = print_e & ~pe_q;
  assign bit_end  = (baud_q == BAUD_END);
  assign next_bit = bit_q + 3'd1;
  // The byte on the wire is always the top of the buffer; it shifts up between bytes.
  assign cur_byte = buf_q[BW-1 -: 8];
`ifdef PACKET_UART_SYNC_EN
  assign capture  = {8'hA5, packet};
`else
  assign capture  = packet;
`endif

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q + 16'd1;
    bit_d   = bit_q;
    idx_d   = idx_q;
    buf_d   = buf_q;
    txd_d   = txd_q;
    busy_d  = busy_q;
    ovr_d   = ovr_q | (rise & busy_q);
    fcnt_d  = fcnt_q;
    case (state_q)
      S_IDLE: begin
        baud_d = 16'd0;
        txd_d  = 1'b1;
        if (rise) begin
          buf_d   = capture;
          idx_d   = '0;
          busy_d  = 1'b1;
          txd_d   = 1'b0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          baud_d  = 16'd0;
          bit_d   = 3'd0;
          txd_d   = cur_byte[0];
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          baud_d = 16'd0;
          if (bit_q == 3'd7) begin
            txd_d   = 1'b1;
            state_d = S_STOP;
          end else begin
            bit_d = next_bit;
            txd_d = cur_byte[next_bit];
          end
        end
      end
      S_STOP: begin
        if (bit_end) begin
          baud_d = 16'd0;
          if (idx_q != LAST_IDX) begin
            idx_d   = idx_q + 1'b1;
            buf_d   = buf_q << 8;
            txd_d   = 1'b0;
            state_d = S_START;
          end else begin
            busy_d  = 1'b0;
            fcnt_d  = fcnt_q + 16'd1;
            txd_d   = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pe_q    <= 1'b0;
      baud_q  <= 16'd0;
      bit_q   <= 3'd0;
      idx_q   <= '0;
      buf_q   <= '0;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
      ovr_q   <= 1'b0;
      fcnt_q  <= 16'd0;
    end else begin
      state_q <= state_d;
      pe_q    <= print_e;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      idx_q   <= idx_d;
      buf_q   <= buf_d;
      txd_q   <= txd_d;
      busy_q  <= busy_d;
      ovr_q   <= ovr_d;
      fcnt_q  <= fcnt_d;
    end
  end

  assign TxD       = txd_q;
  assign busy      = busy_q;
  assign overrun   = ovr_q;
  assign frame_cnt = fcnt_q;

endmodule

// File: tb/tb_packet_uart_tx.sv
// tb/tb_packet_uart_tx.sv - randomized bench for packet_uart_tx against a byte/bit-list reference model.
module tb_packet_uart_tx;
  localparam int CD = 4;
  localparam int PB = 22;
`ifdef PACKET_UART_SYNC_EN
  localparam int NB = PB + 1;
`else
  localparam int NB = PB;
`endif
  localparam int FRAME = NB * 10 * CD;

  logic            clk = 1'b0;
  logic            rst;
  logic            print_e, print_e1;
  logic [8*PB-1:0] packet;
  logic [7:0]      packet1;
  logic            txd, busy, overrun, txd1, busy1, ovr1;
  logic [15:0]     frame_cnt, fc1;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;
  int len;
  logic [7:0] exp_bytes[$];
  logic       exp_bits[$];

  packet_uart_tx #(.CLK_DIV(CD), .PKT_BYTES(PB)) dut (
    .clk(clk), .rst(rst), .print_e(print_e), .packet(packet),
    .TxD(txd), .busy(busy), .overrun(overrun), .frame_cnt(frame_cnt)
  );

  packet_uart_tx #(.CLK_DIV(CD), .PKT_BYTES(1)) dut1 (
    .clk(clk), .rst(rst), .print_e(print_e1), .packet(packet1),
    .TxD(txd1), .busy(busy1), .overrun(ovr1), .frame_cnt(fc1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: frame = optional sync byte, then packet bytes MSB first; each byte is 0, 8 data LSB first, 1.
  task automatic model_frame(input logic [8*PB-1:0] p, input int nbytes);
    exp_bytes.delete();
    exp_bits.delete();
`ifdef PACKET_UART_SYNC_EN
    exp_bytes.push_back(8'hA5);
`endif
    for (int i = 0; i < nbytes; i++) exp_bytes.push_back(p[8*(nbytes-1-i) +: 8]);
    foreach (exp_bytes[k]) begin
      exp_bits.push_back(1'b0);
      for (int j = 0; j < 8; j++) exp_bits.push_back(exp_bytes[k][j]);
      exp_bits.push_back(1'b1);
    end
  endtask

  task automatic rand_packet();
    for (int i = 0; i < PB; i++) packet[8*i +: 8] = 8'($urandom);
  endtask

  task automatic run_frame(input string tag, input int iso_at, input int ovr_at,
                           input int rst_at, output int blen);
    int c, bad;
    logic smp[$];
    logic [7:0] b;
    bad = 0;
    print_e = 1'b1;
    @(negedge clk);
    print_e = 1'b0;
    c = 0;
    while (busy === 1'b1 && c < FRAME + 20) begin
      if (c / CD < exp_bits.size()) begin
        if (txd !== exp_bits[c/CD]) bad++;
      end else bad++;
      if (c % CD == CD / 2) smp.push_back(txd);
      if (c == iso_at) packet = '0;
      print_e = (c == ovr_at);
      if (c == rst_at) rst = 1'b1;
      @(negedge clk);
      c++;
    end
    print_e = 1'b0;
    blen = c;
    if (rst_at < 0) begin
      check({tag, " busy_len"}, 64'(c), 64'(FRAME));
      check({tag, " wave_err"}, 64'(bad), 64'd0);
      check({tag, " samples"}, 64'(smp.size()), 64'(10 * NB));
      if (smp.size() >= 10 * NB) begin
        for (int k = 0; k < NB; k++) begin
          for (int j = 0; j < 8; j++) b[j] = smp[10*k + 1 + j];
          check($sformatf("%s byte%0d", tag, k), 64'(b), 64'(exp_bytes[k]));
        end
      end
      check({tag, " txd_idle"}, 64'(txd), 64'd1);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int bad1, c1, busy_seen;
    rst = 1'b1;
    print_e = 1'b0;
    print_e1 = 1'b0;
    packet = '0;
    packet1 = 8'hA0;

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("reset_outs%0d", i), {txd, busy, overrun, frame_cnt}, {1'b1, 1'b0, 1'b0, 16'h0});
      print_e = ~print_e;
    end
    rst = 1'b0;
    print_e = 1'b0;
    @(negedge clk);

    for (int i = 0; i < PB; i++) packet[8*(PB-1-i) +: 8] = 8'(i + 1);
    model_frame(packet, PB);
    run_frame("single", -1, -1, -1, len);
    check("single frame_cnt", 64'(frame_cnt), 64'd1);
    check("single overrun", 64'(overrun), 64'd0);

    rand_packet();
    model_frame(packet, PB);
    run_frame("isolate", 10, -1, -1, len);
    check("isolate frame_cnt", 64'(frame_cnt), 64'd2);

    do_reset();
    check("rst frame_cnt", 64'(frame_cnt), 64'd0);
    rand_packet();
    model_frame(packet, PB);
    run_frame("overrun", -1, 100, -1, len);
    check("overrun flag", 64'(overrun), 64'd1);
    check("overrun frame_cnt", 64'(frame_cnt), 64'd1);
    rand_packet();
    model_frame(packet, PB);
    run_frame("after_ovr", -1, -1, -1, len);
    check("after_ovr frame_cnt", 64'(frame_cnt), 64'd2);
    check("after_ovr sticky", 64'(overrun), 64'd1);

    do_reset();
    rand_packet();
    model_frame(packet, PB);
    run_frame("late_rise", -1, FRAME - 1, -1, len);
    busy_seen = 0;
    for (int i = 0; i < 2 * CD; i++) begin
      if (busy !== 1'b0) busy_seen++;
      @(negedge clk);
    end
    check("late_rise no_restart", 64'(busy_seen), 64'd0);
    check("late_rise overrun", 64'(overrun), 64'd1);
    check("late_rise frame_cnt", 64'(frame_cnt), 64'd1);

    do_reset();
    rand_packet();
    model_frame(packet, PB);
    run_frame("midrst", -1, -1, 300, len);
    check("midrst txd_busy", {txd, busy}, 2'b10);
    check("midrst frame_cnt", 64'(frame_cnt), 64'd0);
    check("midrst len", 64'(len), 64'd301);
    rst = 1'b0;
    @(negedge clk);

    for (int r = 0; r < 3; r++) begin
      rand_packet();
      model_frame(packet, PB);
      run_frame($sformatf("rand%0d", r), -1, -1, -1, len);
      check($sformatf("rand%0d frame_cnt", r), 64'(frame_cnt), 64'(r + 1));
    end

    model_frame({{(8*PB-8){1'b0}}, packet1}, 1);
    print_e1 = 1'b1;
    @(negedge clk);
    print_e1 = 1'b0;
    bad1 = 0;
    c1 = 0;
    while (busy1 === 1'b1 && c1 < 40 * CD) begin
      if (c1 / CD >= exp_bits.size() || txd1 !== exp_bits[c1/CD]) bad1++;
      @(negedge clk);
      c1++;
    end
    check("bitorder wave_err", 64'(bad1), 64'd0);
    check("bitorder len", 64'(c1), 64'(exp_bits.size() * CD));
    check("bitorder frame_cnt", 64'(fc1), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
